mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that answers the processor's data-memory port: mem_read, mem_write, address, write data and read data.
- Sits beside the data memory. The top level steers MEM-stage accesses to it when hit_o=1 and muxes its data_o into the MEM/WB read-data path.
- Buffers written bytes in a FIFO and serialises them 8N1, LSB first, on tx_o.

Parameters:
- BASE_ADDR, 32'h1001_0100: 16-byte-aligned base of the register window.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16: width of the baud divisor register.
- RESET_DIV, 434: reset value of BAUD_DIV, in clocks per bit.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- mem_read_i, input, 1: MEM-stage read strobe.
- mem_write_i, input, 1: MEM-stage write strobe.
- address_i, input, 32: byte address from the ALU result.
- write_data_i, input, 32: store data.
- data_o, output, 32: read data; combinational, same cycle.
- hit_o, output, 1: address_i[31:4]==BASE_ADDR[31:4].
- tx_o, output, 1: serial line; idle level is high.

Behaviour:
- Register map, offset = address_i[3:2]:
  - 0 TXDATA (W): a write pushes write_data_i[7:0]. A read returns 0.
  - 1 STATUS (R/W1C): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] fifo count, all other bits 0. Writing 1 to bit3 clears it.
  - 2 BAUD_DIV (R/W): bits[DIV_WIDTH-1:0]; upper bits read as 0.
  - 3 CTRL (R/W): bit0 tx_enable, reset value 1.
- Access rules:
  - Writes take effect on a clk edge only when mem_write_i & hit_o.
  - data_o is 0 when mem_read_i=0 or hit_o=0.
  - address_i[1:0] is ignored.
- Reset values:
  - tx_o=1; FSM in IDLE; FIFO empty with count 0; overflow 0.
  - BAUD_DIV=RESET_DIV; CTRL=1.
- FIFO:
  - A push while full (registered count==FIFO_DEPTH) is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle while not full: count is unchanged and the data order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM, states IDLE, START, DATA, STOP:
  - IDLE: when tx_enable & !empty, pop the head into a shift register, load the bit counter, and go to START. tx_o stays 1 in the transition cycle.
  - START: tx_o=0 for one bit period.
  - DATA: 8 bit periods, tx_o=shift[0], shift right at the end of each period.
  - STOP: tx_o=1 for one bit period, then IDLE. Back-to-back frames therefore carry one idle cycle between STOP and the next START.
- Bit period:
  - Lasts D = max(BAUD_DIV,1) cycles.
  - The down-counter reloads D-1 on entry to each bit and the bit ends when the counter reaches 0.
  - D is sampled at each reload, so a BAUD_DIV write mid-frame applies from the next bit.
- Frame latency:
  - A write to an empty FIFO with the FSM idle gives the start-bit falling edge 2 cycles after the write edge.
  - A frame is 10*D cycles.
- Clearing tx_enable mid-frame completes the current frame and then holds IDLE.
- Reset mid-frame: tx_o=1 on the next edge and all queued bytes are discarded.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined:
  - CTRL bit1 = parity_en and CTRL bit2 = odd.
  - A PARITY state between DATA and STOP sends the XOR of the data bits, inverted when odd=1, for one bit period.
  - The frame is 11*D cycles when parity_en=1.
- When undefined: CTRL bits[2:1] read 0, writes to them are ignored, and no PARITY state exists.

Decomposition:
- Package uart_mmio_pkg:
  - Register offset constants for TXDATA, STATUS, BAUD_DIV and CTRL.
  - STATUS and CTRL bit indices.
  - FSM state encoding.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports push, pop, din, dout, full, empty, count.
  - Synchronous active-high reset.
- The top block holds the decode, registers, FSM and baud counter.

Test Plan:
- Reset, then read STATUS: data_o=32'h0000_0004 (empty only), tx_o=1, BAUD_DIV reads 434, CTRL reads 1.
- Set BAUD_DIV=4 and write 0xA5 to TXDATA: after 2 cycles tx_o=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. busy falls 40 cycles after the start.
- With CTRL=0, write 9 bytes: the first 8 are accepted with count 8 and full=1. The 9th is dropped and STATUS bit3=1. Writing 8 to STATUS clears bit3.
- BAUD_DIV=2 with 3 queued bytes 0x01, 0x02, 0x03: three frames of 20 cycles with 1 idle cycle between them, bytes in order.
- Reset asserted 7 cycles into a frame: the next edge gives tx_o=1 and STATUS empty=1. A read to address BASE_ADDR+16 gives hit_o=0 and data_o=0.
- UART_PARITY_EN defined, CTRL=3, BAUD_DIV=2, byte 0x07: the parity bit is 1, giving an 11-bit frame of 22 cycles. With CTRL=7 the parity bit is 0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions and the TX FSM state encoding.
// Optional parity support is enabled by defining UART_PARITY_EN.
package uart_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PAR = 1;
  localparam int CTRL_ODD = 2;

`ifdef UART_PARITY_EN
  localparam int CTRL_W = 3;
`else
  localparam int CTRL_W = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory style MMIO port shared by the CPU MEM stage and the UART.
interface mmio_uart_tx_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic [31:0] data_o;
  logic        hit_o;

  modport master (output mem_read_i, mem_write_i, address_i, write_data_i,
                  input  data_o, hit_o);
  modport slave  (input  mem_read_i, mem_write_i, address_i, write_data_i,
                  output data_o, hit_o);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rp];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array: no reset needed, validity tracked by count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud
// counter and serialiser FSM. Define UART_PARITY_EN to add CTRL
// parity_en/odd bits and a parity bit between data and stop.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0100,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DIV_WIDTH  = 16,
  parameter int          RESET_DIV  = 434
) (
  input  logic            clk,
  input  logic            reset,
  mmio_uart_tx_if.slave   bus,
  output logic            tx_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e            r_state;
  logic                 r_tx, r_ovf;
  logic [DIV_WIDTH-1:0] r_div, r_cnt;
  logic [CTRL_W-1:0]    r_ctrl;
  logic [7:0]           r_shift;
  logic [2:0]           r_bits;
`ifdef UART_PARITY_EN
  logic                 r_par;
`endif

  logic                 w_hit, w_wr, w_push, w_pop, w_full, w_empty;
  logic [1:0]           w_off;
  logic [7:0]           w_dout;
  logic [CW-1:0]        w_count;
  logic [DIV_WIDTH-1:0] w_reload;
  logic [31:0]          w_status;
  logic                 w_unused_bits;

  assign w_hit    = (bus.address_i[31:4] == BASE_ADDR[31:4]);
  assign w_off    = bus.address_i[3:2];
  assign w_wr     = bus.mem_write_i & w_hit;
  assign w_push   = w_wr && (w_off == OFF_TXDATA);
  assign w_pop    = (r_state == S_IDLE) && r_ctrl[CTRL_EN] && !w_empty;
  // A zero divisor behaves as one clock per bit.
  assign w_reload = (r_div == '0) ? '0 : r_div - 1'b1;
  assign bus.hit_o = w_hit;
  assign tx_o     = r_tx;
  assign w_unused_bits = ^{bus.address_i[1:0], bus.write_data_i};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(w_push), .pop(w_pop),
    .din(bus.write_data_i[7:0]), .dout(w_dout),
    .full(w_full), .empty(w_empty), .count(w_count)
  );

  // STATUS word assembly.
  always_comb begin
    w_status                  = '0;
    w_status[ST_BUSY]         = (r_state != S_IDLE);
    w_status[ST_FULL]         = w_full;
    w_status[ST_EMPTY]        = w_empty;
    w_status[ST_OVF]          = r_ovf;
    w_status[ST_CNT_LSB +: 4] = 4'(w_count);
  end

  // Same-cycle read mux; zero unless this block is addressed and read.
  always_comb begin
    bus.data_o = '0;
    if (bus.mem_read_i && w_hit) begin
      case (w_off)
        OFF_STATUS: bus.data_o = w_status;
        OFF_BAUD:   bus.data_o = 32'(r_div);
        OFF_CTRL:   bus.data_o = 32'(r_ctrl);
        default:    bus.data_o = '0;
      endcase
    end
  end

  // Software-visible registers; overflow set wins over its W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= DIV_WIDTH'(RESET_DIV);
      r_ctrl <= CTRL_W'(1);
      r_ovf  <= 1'b0;
    end else begin
      if (w_push && w_full)
        r_ovf <= 1'b1;
      else if (w_wr && w_off == OFF_STATUS && bus.write_data_i[ST_OVF])
        r_ovf <= 1'b0;
      if (w_wr && w_off == OFF_BAUD) r_div  <= bus.write_data_i[DIV_WIDTH-1:0];
      if (w_wr && w_off == OFF_CTRL) r_ctrl <= bus.write_data_i[CTRL_W-1:0];
    end
  end

  // Serialiser FSM; tx_o is registered from the current state, so the
  // line trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
`ifdef UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_dout;
            r_bits  <= 3'd7;
            r_cnt   <= w_reload;
            r_state <= S_START;
`ifdef UART_PARITY_EN
            r_par   <= ^w_dout;
`endif
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (r_cnt == '0) begin
            r_cnt   <= w_reload;
            r_state <= S_DATA;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (r_cnt == '0) begin
            r_cnt   <= w_reload;
            r_shift <= r_shift >> 1;
            if (r_bits == '0) begin
`ifdef UART_PARITY_EN
              r_state <= r_ctrl[CTRL_PAR] ? S_PARITY : S_STOP;
`else
              r_state <= S_STOP;
`endif
            end else r_bits <= r_bits - 1'b1;
          end else r_cnt <= r_cnt - 1'b1;
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          r_tx <= r_par ^ r_ctrl[CTRL_ODD];
          if (r_cnt == '0) begin
            r_cnt   <= w_reload;
            r_state <= S_STOP;
          end else r_cnt <= r_cnt - 1'b1;
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register table, framing, FIFO
// overflow, back-to-back frames, mid-frame reset and optional parity.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1001_0100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_o;

  mmio_uart_tx_if bus_if();

  mmio_uart_tx dut (.clk(clk), .reset(reset), .bus(bus_if), .tx_o(tx_o));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  int         starts[$];
  bit         mon_en  = 1'b0;
  int         div     = 434;
  bit         par_on  = 1'b0;
  bit         par_odd = 1'b0;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.mem_write_i  = 1'b1;
    bus_if.address_i    = a;
    bus_if.write_data_i = d;
    @(negedge clk);
    bus_if.mem_write_i  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    bus_if.mem_read_i = 1'b1;
    bus_if.address_i  = a;
    #1;
    d = bus_if.data_o;
    h = bus_if.hit_o;
    bus_if.mem_read_i = 1'b0;
  endtask

  // Serial monitor: decodes frames from tx_o and checks them against
  // the expected-byte queue filled when bytes are written.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic [7:0] e;
    logic       pb;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx_o) begin
        starts.push_back(cyc);
        b  = '0;
        pb = 1'b0;
        repeat (div / 2) @(negedge clk);
        chk("start_bit", {31'd0, tx_o}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (div) @(negedge clk);
          b[i] = tx_o;
        end
        if (par_on) begin
          repeat (div) @(negedge clk);
          pb = tx_o;
        end
        repeat (div) @(negedge clk);
        chk("stop_bit", {31'd0, tx_o}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got %h expected none", b);
        end else begin
          e = exp_q.pop_front();
          chk("frame_byte", {24'd0, b}, {24'd0, e});
          if (par_on) chk("parity_bit", {31'd0, pb}, {31'd0, (^e) ^ par_odd});
        end
      end
      prev = tx_o;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [17];
    logic [31:0] d;
    logic        h;
    logic [9:0]  fr;
    logic        bad;
    logic [31:0] ctrl7_rb;

`ifdef UART_PARITY_EN
    ctrl7_rb = 32'd7;
`else
    ctrl7_rb = 32'd1;
`endif
    tbl[0]  = '{"rst_status",      0, 1, BASE+4,  0,            1, 32'h4,    1};
    tbl[1]  = '{"rst_baud",        0, 1, BASE+8,  0,            1, 32'd434,  1};
    tbl[2]  = '{"rst_ctrl",        0, 1, BASE+12, 0,            1, 32'd1,    1};
    tbl[3]  = '{"txdata_rd0",      0, 1, BASE+0,  0,            1, 32'd0,    1};
    tbl[4]  = '{"miss_rd",         0, 1, BASE+16, 0,            1, 32'd0,    0};
    tbl[5]  = '{"no_rd_strobe",    0, 0, BASE+4,  0,            1, 32'd0,    1};
    tbl[6]  = '{"lowbits_ignored", 0, 1, BASE+7,  0,            1, 32'h4,    1};
    tbl[7]  = '{"wr_baud",         1, 0, BASE+8,  32'hABCD1234, 0, 32'd0,    1};
    tbl[8]  = '{"baud_rw",         0, 1, BASE+8,  0,            1, 32'h1234, 1};
    tbl[9]  = '{"wr_miss",         1, 0, BASE+24, 32'd7,        0, 32'd0,    0};
    tbl[10] = '{"miss_wr_ignored", 0, 1, BASE+8,  0,            1, 32'h1234, 1};
    tbl[11] = '{"wr_ctrl7",        1, 0, BASE+12, 32'd7,        0, 32'd0,    1};
    tbl[12] = '{"ctrl_mask",       0, 1, BASE+12, 0,            1, ctrl7_rb, 1};
    tbl[13] = '{"wr_ctrl1",        1, 0, BASE+12, 32'd1,        0, 32'd0,    1};
    tbl[14] = '{"ctrl_rw",         0, 1, BASE+12, 0,            1, 32'd1,    1};
    tbl[15] = '{"wr_status_ff",    1, 0, BASE+4,  32'hFFFFFFFF, 0, 32'd0,    1};
    tbl[16] = '{"status_w1c_idle", 0, 1, BASE+4,  0,            1, 32'h4,    1};

    bus_if.mem_read_i   = 1'b0;
    bus_if.mem_write_i  = 1'b0;
    bus_if.address_i    = '0;
    bus_if.write_data_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_tx", {31'd0, tx_o}, 32'd1);

    // Register table
    foreach (tbl[i]) begin
      @(negedge clk);
      bus_if.mem_write_i  = tbl[i].we;
      bus_if.mem_read_i   = tbl[i].re;
      bus_if.address_i    = tbl[i].addr;
      bus_if.write_data_i = tbl[i].wdata;
      #1;
      if (tbl[i].chk) begin
        chk({tbl[i].name, "_data"}, bus_if.data_o, tbl[i].exp_data);
        chk({tbl[i].name, "_hit"}, {31'd0, bus_if.hit_o}, {31'd0, tbl[i].exp_hit});
      end
    end
    @(negedge clk);
    bus_if.mem_write_i = 1'b0;
    bus_if.mem_read_i  = 1'b0;

    // 0xA5 at D=4: exact line pattern and busy timing
    wr(BASE+8, 32'd4);
    div    = 4;
    mon_en = 1'b1;
    exp_q.push_back(8'hA5);
    wr(BASE+0, 32'hA5);
    bus_if.mem_read_i = 1'b1;
    bus_if.address_i  = BASE+4;
    @(negedge clk);
    chk("launch_cycle_tx_high", {31'd0, tx_o}, 32'd1);
    fr  = {1'b1, 8'hA5, 1'b0};
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) chk("start_fall_2cyc", {31'd0, tx_o}, 32'd0);
      if (tx_o !== fr[k/4]) bad = 1'b1;
      if (k == 38) chk("busy_in_stop", {31'd0, bus_if.data_o[0]}, 32'd1);
      if (k == 39) chk("busy_fall", {31'd0, bus_if.data_o[0]}, 32'd0);
    end
    chk("frame_a5_pattern", {31'd0, bad}, 32'd0);
    bus_if.mem_read_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("a5_consumed", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    // Overflow with transmitter disabled
    wr(BASE+12, 32'd0);
    for (int i = 0; i < 8; i++) wr(BASE+0, 32'h10 + i);
    rd(BASE+4, d, h);
    chk("full_status", d, 32'h0000_0802);
    wr(BASE+0, 32'h99);
    rd(BASE+4, d, h);
    chk("overflow_status", d, 32'h0000_080A);
    wr(BASE+4, 32'd8);
    rd(BASE+4, d, h);
    chk("overflow_w1c", d, 32'h0000_0802);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(BASE+4, d, h);
    chk("reset_flush", d, 32'h4);

    // Three queued bytes at D=2: order and spacing
    wr(BASE+8, 32'd2);
    div = 2;
    wr(BASE+12, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      wr(BASE+0, i);
    end
    starts.delete();
    mon_en = 1'b1;
    wr(BASE+12, 32'd1);
    repeat (80) @(negedge clk);
    chk("b2b_frames", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      chk("b2b_gap01", starts[1] - starts[0], 32'd21);
      chk("b2b_gap12", starts[2] - starts[1], 32'd21);
    end
    chk("b2b_consumed", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    // Reset 7 cycles into a frame
    wr(BASE+8, 32'd4);
    wr(BASE+0, 32'h00);
    wr(BASE+0, 32'h00);
    repeat (6) @(negedge clk);
    chk("pre_reset_tx_low", {31'd0, tx_o}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_tx_next_edge", {31'd0, tx_o}, 32'd1);
    reset = 1'b0;
    rd(BASE+4, d, h);
    chk("reset_mid_status", d, 32'h4);
    repeat (30) @(negedge clk);
    chk("no_frame_after_reset", {31'd0, tx_o}, 32'd1);
    rd(BASE+16, d, h);
    chk("base16_hit", {31'd0, h}, 32'd0);
    chk("base16_data", d, 32'd0);

`ifdef UART_PARITY_EN
    // Parity frames, even then odd
    wr(BASE+8, 32'd2);
    div     = 2;
    par_on  = 1'b1;
    par_odd = 1'b0;
    wr(BASE+12, 32'd3);
    mon_en = 1'b1;
    exp_q.push_back(8'h07);
    wr(BASE+0, 32'h07);
    repeat (30) @(negedge clk);
    par_odd = 1'b1;
    wr(BASE+12, 32'd7);
    exp_q.push_back(8'h07);
    wr(BASE+0, 32'h07);
    repeat (30) @(negedge clk);
    chk("parity_consumed", exp_q.size(), 32'd0);
    mon_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
